sega_cart_mapper: RTL and testbench
===================================

# sega_cart_mapper

Cartridge-side memory subsystem for the Game Gear core. It translates 16-bit Z80 memory addresses into 22-bit ROM addresses using standard Sega paging registers, and serves ROM bytes from an internal asynchronous-read memory. It also provides the divided CPU clock. It sits between the MMU's cartridge port and the ROM storage.

## Interface
Parameters:
- `DIV_COUNT`, default 7: input cycles per half-period of `div_clk`; legal range ≥ 1.
- `ROM_ASZ`, default 18: ROM address width; depth = 2^ROM_ASZ bytes (256 KiB).

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `div_clk`  out  1  divided clock, registered.
- `wr`  in  1  CPU memory write strobe (level, = MREQ & WR).
- `addr`  in  16  CPU address.
- `di`  in  8  CPU write data.
- `flash_addr`  out  22  translated ROM address, combinational.
- `rom_do`  out  8  ROM byte at `flash_addr[ROM_ASZ-1:0]`, combinational.
- `ram_sel`  out  1  high when cart-RAM is mapped into the current access.
- `ctrl`, `bank0`, `bank1`, `bank2`  out  8 each  mapper register contents.
- `load_we`  in  1  ROM load write enable.
- `load_addr`  in  ROM_ASZ  ROM load address.
- `load_data`  in  8  ROM load data.

## Operation
- **Mapper registers**
  - On a rising `clk` edge with `wr`=1, the register selected by `addr` is written from `di`:
    - `addr`=0xFFFC writes `ctrl`.
    - 0xFFFD writes `bank0`.
    - 0xFFFE writes `bank1`.
    - 0xFFFF writes `bank2`.
  - Any other address leaves the registers unchanged.
  - A write held across several cycles rewrites the same value and is harmless.
- **Address translation** (combinational, from `addr`):
  - 0x0000–0x03FF → `{8'h00, addr[13:0]}`. The first 1 KiB is never paged.
  - 0x0400–0x3FFF → `{bank0, addr[13:0]}`.
  - 0x4000–0x7FFF → `{bank1, addr[13:0]}`.
  - 0x8000–0xBFFF → `{bank2, addr[13:0]}`.
  - 0xC000–0xFFFF → `{8'h00, addr[13:0]}`. The result is don't-care for the system, but this value is required.
- **ram_sel** = `ctrl[3]` AND `addr` in 0x8000–0xBFFF. `flash_addr` is still computed from `bank2` in that case.
- **ROM**
  - `rom_do` = `mem[flash_addr[ROM_ASZ-1:0]]`. Upper bits are ignored, so bank numbers wrap modulo the ROM size.
  - The read path is purely combinational and has no clock dependence.
  - On a rising `clk` edge with `load_we`=1, `mem[load_addr]` ← `load_data`. The CPU `wr` never writes the ROM.
  - ROM contents are unaffected by reset. Simulation may preload them with `$readmemh`.
- **Clock divider**
  - Counter runs 0..DIV_COUNT-1.
  - When the counter equals DIV_COUNT-1, it returns to 0 and `div_clk` toggles; otherwise the counter increments.
  - The period of `div_clk` is 2·DIV_COUNT `clk` cycles with 50 % duty.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - `ctrl`=0x00, `bank0`=0x00, `bank1`=0x01, `bank2`=0x02.
  - Divider counter=0, `div_clk`=0.
  - With `addr` held, `flash_addr` after reset therefore follows the identity map for 0x0000–0xBFFF.
- Reset has priority over simultaneous `wr`/register writes. `load_we` is honoured during reset.
- Register write latency: 1 cycle. A new bank value affects `flash_addr`/`rom_do` combinationally after the edge that captured it.
- ROM load-then-read at the same address: read returns the new data after the write edge. A same-cycle read returns the old data.
- Divider: first `div_clk` rise occurs at the DIV_COUNT-th rising edge after reset release. It toggles every DIV_COUNT edges thereafter.
- Reset asserted mid-count clears the divider on that edge.

## Test plan
- **Reset defaults:** pulse `reset_n` low for 1 cycle; `addr`=0x4123 → `flash_addr`=0x04123. `addr`=0x8001 → 0x08001. Registers read 00/00/01/02.
- **Bank switch:** `wr`=1, `addr`=0xFFFF, `di`=0x05 for one cycle; then `addr`=0x8010 → `flash_addr`=0x14010, and `rom_do` equals the loaded byte at 0x14010.
- **Fixed first 1 KiB:** write `bank0`=0x07; `addr`=0x0200 → 0x00200; `addr`=0x0400 → 0x1C400.
- **Wrap:** write `bank1`=0x13 (ROM_ASZ=18); `addr`=0x4000 → `flash_addr`=0x4C000, and `rom_do` = `mem[0x0C000]`.
- **ram_sel:** write `ctrl`=0x08; `addr`=0x9000 → `ram_sel`=1; `addr`=0x7000 → `ram_sel`=0; write `ctrl`=0x00 → `ram_sel`=0 for `addr`=0x9000.
- **Divider:** DIV_COUNT=7; after reset release, `div_clk` rises at edge 7 and falls at edge 14, giving a period of 14 cycles. Assert reset at edge 10 → `div_clk`=0, and the next rise is 7 edges after release.

Source files
------------

// File: rtl/sega_cart_mapper_if.sv
// CPU cartridge bus and ROM load port between the MMU and the Sega cartridge mapper.
// The master drives the strobes, address and data; the slave returns the translated address and ROM data.
interface sega_cart_mapper_if #(
    parameter int ROM_ASZ = 18
);
    logic               wr;
    logic [15:0]        addr;
    logic [7:0]         di;
    logic [21:0]        flash_addr;
    logic [7:0]         rom_do;
    logic               ram_sel;
    logic [7:0]         ctrl;
    logic [7:0]         bank0;
    logic [7:0]         bank1;
    logic [7:0]         bank2;
    logic               load_we;
    logic [ROM_ASZ-1:0] load_addr;
    logic [7:0]         load_data;

    modport master (
        output wr, addr, di, load_we, load_addr, load_data,
        input  flash_addr, rom_do, ram_sel, ctrl, bank0, bank1, bank2
    );

    modport slave (
        input  wr, addr, di, load_we, load_addr, load_data,
        output flash_addr, rom_do, ram_sel, ctrl, bank0, bank1, bank2
    );
endinterface

// File: rtl/sega_cart_mapper.sv
// Sega-style cartridge mapper: paging registers, Z80-to-ROM address translation,
// an asynchronous-read ROM with a load port, and the divided CPU clock.
module sega_cart_mapper #(
    parameter int DIV_COUNT = 7,
    parameter int ROM_ASZ   = 18
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               div_clk,
    sega_cart_mapper_if.slave  bus
);
    localparam int            CW       = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_COUNT - 1);

    logic [7:0]    r_ctrl;
    logic [7:0]    r_bank0;
    logic [7:0]    r_bank1;
    logic [7:0]    r_bank2;
    logic [CW-1:0] r_div_cnt;
    logic          r_div_clk;
    logic [7:0]    r_mem [0:(1 << ROM_ASZ) - 1];

    logic [1:0]    w_page;
    logic          w_fixed_low;
    logic [7:0]    w_bank_sel;
    logic [21:0]   w_flash_addr;

    // Register writes are ignored while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl  <= 8'h00;
            r_bank0 <= 8'h00;
            r_bank1 <= 8'h01;
            r_bank2 <= 8'h02;
        end else if (bus.wr) begin
            case (bus.addr)
                16'hFFFC: r_ctrl  <= bus.di;
                16'hFFFD: r_bank0 <= bus.di;
                16'hFFFE: r_bank1 <= bus.di;
                16'hFFFF: r_bank2 <= bus.di;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_div_clk <= 1'b0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_div_clk <= ~r_div_clk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign w_page      = bus.addr[15:14];
    assign w_fixed_low = (bus.addr[15:10] == 6'b000000);

    // The interrupt vectors in the first 1 KiB stay on bank 0 regardless of bank0.
    always_comb begin
        w_bank_sel = 8'h00;
        if (!w_fixed_low) begin
            case (w_page)
                2'd0:    w_bank_sel = r_bank0;
                2'd1:    w_bank_sel = r_bank1;
                2'd2:    w_bank_sel = r_bank2;
                default: w_bank_sel = 8'h00;
            endcase
        end
    end

    assign w_flash_addr = {w_bank_sel, bus.addr[13:0]};

    // ROM contents survive reset; only the load port writes them.
    always_ff @(posedge clk) begin
        if (bus.load_we) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.flash_addr = w_flash_addr;
    assign bus.rom_do     = r_mem[w_flash_addr[ROM_ASZ-1:0]];
    assign bus.ram_sel    = r_ctrl[3] & (w_page == 2'd2);
    assign bus.ctrl       = r_ctrl;
    assign bus.bank0      = r_bank0;
    assign bus.bank1      = r_bank1;
    assign bus.bank2      = r_bank2;
    assign div_clk        = r_div_clk;
endmodule

// File: tb/tb_sega_cart_mapper.sv
// Randomised and directed check of the cartridge mapper against a behavioural model
// of the paging rules, ROM contents and clock divider.
module tb_sega_cart_mapper;
    localparam int DIVC = 7;
    localparam int ASZ  = 18;

    logic clk = 1'b0;
    logic reset_n;
    wire  div_clk;

    sega_cart_mapper_if #(.ROM_ASZ(ASZ)) bus ();

    sega_cart_mapper #(.DIV_COUNT(DIVC), .ROM_ASZ(ASZ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div_clk (div_clk),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    logic [7:0] m_mem [0:(1 << ASZ) - 1];
    bit         m_val [0:(1 << ASZ) - 1];
    logic [7:0] m_ctrl, m_b0, m_b1, m_b2;
    int         m_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Each 16 KiB slot of the CPU map selects a bank; the lowest 1 KiB and the top slot use bank 0.
    function automatic logic [21:0] exp_flash(input logic [15:0] a);
        int bank;
        if (a < 16'h0400)      bank = 0;
        else if (a < 16'h4000) bank = int'(m_b0);
        else if (a < 16'h8000) bank = int'(m_b1);
        else if (a < 16'hC000) bank = int'(m_b2);
        else                   bank = 0;
        return 22'(bank * 16384 + int'(a) % 16384);
    endfunction

    always @(posedge clk) begin
        if (bus.load_we) begin
            m_mem[bus.load_addr] = bus.load_data;
            m_val[bus.load_addr] = 1'b1;
        end
        if (!reset_n) begin
            m_ctrl = 8'h00; m_b0 = 8'h00; m_b1 = 8'h01; m_b2 = 8'h02;
            m_cyc  = 0;
        end else begin
            m_cyc++;
            if (bus.wr && bus.addr == 16'hFFFC) m_ctrl = bus.di;
            if (bus.wr && bus.addr == 16'hFFFD) m_b0   = bus.di;
            if (bus.wr && bus.addr == 16'hFFFE) m_b1   = bus.di;
            if (bus.wr && bus.addr == 16'hFFFF) m_b2   = bus.di;
        end
    end

    always @(negedge clk) begin
        logic [21:0] fa;
        logic [ASZ-1:0] ra;
        if (chk_en) begin
            fa = exp_flash(bus.addr);
            ra = fa[ASZ-1:0];
            chk("flash_addr", 32'(bus.flash_addr), 32'(fa));
            chk("ram_sel", 32'(bus.ram_sel),
                32'(m_ctrl[3] && bus.addr >= 16'h8000 && bus.addr < 16'hC000));
            chk("ctrl",  32'(bus.ctrl),  32'(m_ctrl));
            chk("bank0", 32'(bus.bank0), 32'(m_b0));
            chk("bank1", 32'(bus.bank1), 32'(m_b1));
            chk("bank2", 32'(bus.bank2), 32'(m_b2));
            chk("div_clk", 32'(div_clk), 32'((m_cyc / DIVC) % 2));
            if (m_val[ra]) chk("rom_do", 32'(bus.rom_do), 32'(m_mem[ra]));
        end
    end

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        bus.wr = 1'b1; bus.addr = a; bus.di = d;
        @(posedge clk); #2;
        bus.wr = 1'b0;
        $display("wr_reg addr=%04h data=%02h", a, d);
    endtask

    task automatic set_addr(input logic [15:0] a);
        @(posedge clk); #2;
        bus.addr = a;
        #2;
        $display("read addr=%04h flash_addr=%06h rom_do=%02h ram_sel=%0b",
                 a, bus.flash_addr, bus.rom_do, bus.ram_sel);
    endtask

    task automatic div_run(input int n, input int k0);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #2;
            if (k == k0 - 1) chk("div_before_rise", 32'(div_clk), 32'd0);
            if (k == k0)     chk("div_rise", 32'(div_clk), 32'd1);
            if (k == 2 * k0 - 1) chk("div_before_fall", 32'(div_clk), 32'd1);
            if (k == 2 * k0)     chk("div_fall", 32'(div_clk), 32'd0);
        end
    endtask

    initial begin
        logic [1:0]  pg;
        logic [13:0] off;
        logic [7:0]  old_b, new_b;

        reset_n = 1'b0;
        bus.wr = 1'b0; bus.addr = 16'h0000; bus.di = 8'h00;
        bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = 8'h00;

        // Fill offsets 0..31 of every 16 KiB bank; loads proceed while reset is held.
        for (int b = 0; b < 16; b++) begin
            for (int o = 0; o < 32; o++) begin
                @(posedge clk); #2;
                bus.load_we   = 1'b1;
                bus.load_addr = ASZ'(b * 16384 + o);
                bus.load_data = 8'($urandom);
            end
        end
        @(posedge clk); #2;
        bus.load_we = 1'b0;
        chk_en = 1'b1;

        @(posedge clk); #2; reset_n = 1'b0;
        @(posedge clk); #2; reset_n = 1'b1;
        set_addr(16'h4123); chk("reset_map_4123", 32'(bus.flash_addr), 32'h04123);
        set_addr(16'h8001); chk("reset_map_8001", 32'(bus.flash_addr), 32'h08001);
        chk("reset_ctrl",  32'(bus.ctrl),  32'h00);
        chk("reset_bank0", 32'(bus.bank0), 32'h00);
        chk("reset_bank1", 32'(bus.bank1), 32'h01);
        chk("reset_bank2", 32'(bus.bank2), 32'h02);

        wr_reg(16'hFFFF, 8'h05);
        set_addr(16'h8010); chk("bank2_map", 32'(bus.flash_addr), 32'h14010);
        chk("bank2_rom", 32'(bus.rom_do), 32'(m_mem[18'h14010]));

        wr_reg(16'hFFFD, 8'h07);
        set_addr(16'h0200); chk("fixed_1k", 32'(bus.flash_addr), 32'h00200);
        set_addr(16'h0400); chk("bank0_map", 32'(bus.flash_addr), 32'h1C400);

        wr_reg(16'hFFFE, 8'h13);
        set_addr(16'h4000); chk("bank1_wrap", 32'(bus.flash_addr), 32'h4C000);
        chk("wrap_rom", 32'(bus.rom_do), 32'(m_mem[18'h0C000]));

        wr_reg(16'hFFFC, 8'h08);
        set_addr(16'h9000); chk("ram_sel_on", 32'(bus.ram_sel), 32'd1);
        set_addr(16'h7000); chk("ram_sel_slot1", 32'(bus.ram_sel), 32'd0);
        wr_reg(16'hFFFC, 8'h00);
        set_addr(16'h9000); chk("ram_sel_off", 32'(bus.ram_sel), 32'd0);

        // A load becomes visible only after its write edge.
        set_addr(16'h0005);
        old_b = m_mem[18'h00005];
        new_b = ~old_b;
        bus.load_we = 1'b1; bus.load_addr = ASZ'(5); bus.load_data = new_b;
        #1; chk("rom_same_cycle", 32'(bus.rom_do), 32'(old_b));
        @(posedge clk); #2;
        bus.load_we = 1'b0;
        chk("rom_after_load", 32'(bus.rom_do), 32'(new_b));

        @(posedge clk); #2;
        reset_n = 1'b0; bus.wr = 1'b1; bus.addr = 16'hFFFF; bus.di = 8'hAA;
        @(posedge clk); #2;
        reset_n = 1'b1; bus.wr = 1'b0;
        chk("reset_beats_wr", 32'(bus.bank2), 32'h02);
        $display("reset with concurrent write bank2=%02h", bus.bank2);

        @(posedge clk); #2; reset_n = 1'b0;
        @(posedge clk); #2; reset_n = 1'b1;
        div_run(14, DIVC);
        @(posedge clk); #2; reset_n = 1'b0;
        @(posedge clk); #2; reset_n = 1'b1;
        div_run(9, DIVC);
        reset_n = 1'b0;
        @(posedge clk); #2;
        chk("div_mid_reset", 32'(div_clk), 32'd0);
        reset_n = 1'b1;
        div_run(DIVC, DIVC);
        $display("divider directed sequence done");

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            reset_n = ($urandom_range(0, 99) != 0);
            bus.wr  = ($urandom_range(0, 3) == 0);
            if (bus.wr && $urandom_range(0, 4) != 0) begin
                bus.addr = 16'hFFFC + 16'($urandom_range(0, 3));
            end else if ($urandom_range(0, 9) == 0) begin
                bus.addr = 16'($urandom);
            end else begin
                pg  = 2'($urandom_range(0, 3));
                off = 14'($urandom_range(0, 31));
                bus.addr = {pg, off};
            end
            bus.di = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            bus.load_we   = ($urandom_range(0, 19) == 0);
            bus.load_addr = ASZ'($urandom_range(0, 15) * 16384 + $urandom_range(0, 31));
            bus.load_data = 8'($urandom);
        end
        @(posedge clk); #2;
        bus.wr = 1'b0; bus.load_we = 1'b0; reset_n = 1'b1;
        @(posedge clk); #2;
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
